cache_subsystem: RTL and testbench

Direct-mapped, write-back, write-allocate byte cache that sits between the processor request port and the word-wide RAM. It merges the cache controller with the request address and data buffers. On a hit it answers from the line array. On a miss it writes back a dirty victim, fetches the 32-bit block through a cmplt handshake, and then completes the access.

---
 rtl/cache_subsystem_pkg.sv | 13 +
 rtl/cache_subsystem_req_buf.sv | 32 +++
 rtl/cache_subsystem.sv | 128 ++++++++++++
 tb/tb_cache_subsystem.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cache_subsystem_pkg.sv
// cache_subsystem_pkg: shared widths, controller state type and byte-lane helper
package cache_subsystem_pkg;
  localparam int ADDR_W  = 24;
  localparam int INDEX_W = 8;
  localparam int LINE_W  = 32;
  localparam int OFF_W   = 2;
  localparam int TAG_W   = ADDR_W - INDEX_W - OFF_W;
  localparam int LINES   = 1 << INDEX_W;
  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FETCH, RESP} state_e;
  function automatic logic [7:0] sel_byte(input logic [LINE_W-1:0] line, input logic [OFF_W-1:0] off);
    return line[8*off +: 8];
  endfunction
endpackage

// File: rtl/cache_subsystem_req_buf.sv
// req_buf: holds the captured request address, write byte and operation
module req_buf
  import cache_subsystem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        byte_i,
  input  logic              wr_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [7:0]        byte_o,
  output logic              wr_o
);
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        byte_q;
  logic              wr_q;
  // capture the request when the controller accepts it, hold otherwise
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      addr_q <= '0;
      byte_q <= '0;
      wr_q   <= 1'b0;
    end else if (load_i) begin
      addr_q <= addr_i;
      byte_q <= byte_i;
      wr_q   <= wr_i;
    end
  assign addr_o = addr_q;
  assign byte_o = byte_q;
  assign wr_o   = wr_q;
endmodule

// File: rtl/cache_subsystem.sv
// cache_subsystem: direct-mapped write-back write-allocate byte cache in front of a word RAM
module cache_subsystem
  import cache_subsystem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              ack,
  output logic              busy,
  output logic [ADDR_W-1:0] addr_bufout,
  output logic [7:0]        buf_out,
  output logic [ADDR_W-1:0] addr_ram,
  output logic [LINE_W-1:0] data_ram_out,
  input  logic [LINE_W-1:0] data_ram_in,
  output logic              rd_ram,
  output logic              wrt_ram,
  output logic              wrt_bck,
  output logic              fetch,
  input  logic              cmplt
);
  state_e             state_q, state_d;
  logic [LINE_W-1:0]  line_q [LINES];
  logic [TAG_W-1:0]   tag_q [LINES];
  logic [LINES-1:0]   valid_q, dirty_q;
  logic [TAG_W-1:0]   tag;
  logic [INDEX_W-1:0] idx;
  logic [OFF_W-1:0]   off;
  logic [LINE_W-1:0]  cur_line;
  logic               wr_op, load, hit;
  logic [7:0]         data_out_q;
  logic               rd_q, wr_q;
  logic [ADDR_W-1:0]  addr_ram_q;
  logic [LINE_W-1:0]  dout_q;

  req_buf u_req_buf (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .addr_i (addr),
    .byte_i (data_in),
    .wr_i   (write && !read),
    .addr_o (addr_bufout),
    .byte_o (buf_out),
    .wr_o   (wr_op)
  );

  assign {tag, idx, off} = addr_bufout;
  assign cur_line = line_q[idx];
  assign hit = valid_q[idx] && tag_q[idx] == tag;

  // controller state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;

  // next state and request capture; a fetched line loops back to LOOKUP so the access then hits
  always_comb begin
    state_d = state_q;
    load = 1'b0;
    case (state_q)
      IDLE: begin
        load = read || write;
        state_d = load ? LOOKUP : IDLE;
      end
      LOOKUP: state_d = hit ? RESP : (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FETCH;
      WRITEBACK: state_d = cmplt ? FETCH : WRITEBACK;
      FETCH: state_d = cmplt ? LOOKUP : FETCH;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // registered read result and RAM interface; strobes fall the cycle after cmplt is seen
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      data_out_q <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_ram_q <= '0;
      dout_q     <= '0;
    end else begin
      if (state_q == LOOKUP && hit && !wr_op) data_out_q <= sel_byte(cur_line, off);
      wr_q <= state_q == WRITEBACK && !cmplt;
      rd_q <= state_q == FETCH && !cmplt;
      if (state_q == WRITEBACK) begin
        addr_ram_q <= {tag_q[idx], idx, 2'b00};
        dout_q     <= cur_line;
      end else if (state_q == FETCH) begin
        addr_ram_q <= {tag, idx, 2'b00};
      end
    end

  // valid/dirty bookkeeping; a completed write-back leaves the line clean even if the fetch is aborted
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (state_q == LOOKUP && hit && wr_op) begin
      dirty_q[idx] <= 1'b1;
    end else if (state_q == WRITEBACK && cmplt) begin
      dirty_q[idx] <= 1'b0;
    end else if (state_q == FETCH && cmplt) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end

  // line data and tags carry no reset; valid bits alone make them meaningful
  always_ff @(posedge clk)
    if (state_q == LOOKUP && hit && wr_op) line_q[idx][8*off +: 8] <= buf_out;
    else if (state_q == FETCH && cmplt) begin
      line_q[idx] <= data_ram_in;
      tag_q[idx]  <= tag;
    end

  assign data_out     = data_out_q;
  assign ack          = state_q == RESP;
  assign busy         = state_q != IDLE;
  assign addr_ram     = addr_ram_q;
  assign data_ram_out = dout_q;
  assign rd_ram       = rd_q;
  assign fetch        = rd_q;
  assign wrt_ram      = wr_q;
  assign wrt_bck      = wr_q;
endmodule

// File: tb/tb_cache_subsystem.sv
// tb_cache_subsystem: scoreboard bench with a RAM model that completes 2 cycles after a strobe rises
module tb_cache_subsystem;
  logic clk = 0, reset = 1, read = 0, write = 0, cmplt = 0;
  logic [23:0] addr = 0, addr_bufout, addr_ram;
  logic [7:0] data_in = 0, data_out, buf_out;
  logic [31:0] data_ram_out, data_ram_in = 0;
  logic ack, busy, rd_ram, wrt_ram, wrt_bck, fetch;
  int total = 0, bad = 0, acks = 0, ram_cnt = 0;
  logic prev_stb = 0;
  typedef struct {bit rd; logic [23:0] a; logic [7:0] d;} ack_t;
  typedef struct {bit wr; logic [23:0] a; logic [31:0] d;} ram_t;
  ack_t ackq[$];
  ram_t ramq[$];
  ack_t ae;
  ram_t re;
  logic [31:0] mem [int];

  cache_subsystem dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .addr(addr),
    .data_in(data_in), .data_out(data_out), .ack(ack), .busy(busy),
    .addr_bufout(addr_bufout), .buf_out(buf_out), .addr_ram(addr_ram),
    .data_ram_out(data_ram_out), .data_ram_in(data_ram_in), .rd_ram(rd_ram),
    .wrt_ram(wrt_ram), .wrt_bck(wrt_bck), .fetch(fetch), .cmplt(cmplt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic exp_ram(input bit wr, input logic [23:0] a, input logic [31:0] d);
    ramq.push_back(ram_t'{wr, a, d});
  endtask

  task automatic exp_ack(input bit rd, input logic [23:0] a, input logic [7:0] d);
    ackq.push_back(ack_t'{rd, a, d});
  endtask

  task automatic req(input bit rd, input logic [23:0] a, input logic [7:0] d, input bit is_hit);
    int k;
    @(negedge clk);
    read = rd;
    write = !rd;
    addr = a;
    data_in = d;
    @(negedge clk);
    read = 0;
    write = 0;
    chk("busy", busy, 1);
    k = 1;
    while (!ack && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("ack_seen", ack, 1);
    if (is_hit) chk("hit_lat", k, 2);
    @(negedge clk);
  endtask

  // RAM model: checks each transaction against the scoreboard when its strobe rises
  always @(negedge clk) begin
    cmplt = 0;
    if (reset) begin
      prev_stb = 0;
      ram_cnt = 0;
    end else begin
      if ((rd_ram || wrt_ram) && !prev_stb) begin
        ram_cnt = 0;
        chk("flag_wb", wrt_bck, wrt_ram);
        chk("flag_fetch", fetch, rd_ram);
        chk("ram_pending", ramq.size() > 0, 1);
        if (ramq.size() > 0) begin
          re = ramq.pop_front();
          chk("ram_wr", wrt_ram, re.wr);
          chk("ram_addr", addr_ram, re.a);
          if (re.wr) chk("ram_wdata", data_ram_out, re.d);
        end
      end else if (rd_ram || wrt_ram) begin
        ram_cnt++;
        if (ram_cnt == 1) begin
          cmplt = 1;
          if (wrt_ram) mem[int'(addr_ram[23:2])] = data_ram_out;
          else data_ram_in = mem.exists(int'(addr_ram[23:2])) ? mem[int'(addr_ram[23:2])] : 32'h0;
        end
      end
      prev_stb = rd_ram || wrt_ram;
    end
  end

  // ack monitor: pops the expected completion
  always @(negedge clk) begin
    if (!reset && ack) begin
      acks++;
      chk("ack_pending", ackq.size() > 0, 1);
      if (ackq.size() > 0) begin
        ae = ackq.pop_front();
        chk("buf_addr", addr_bufout, ae.a);
        if (ae.rd) chk("rdata", data_out, ae.d);
        else chk("buf_byte", buf_out, ae.d);
      end
    end
  end

  initial begin
    int k, a0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_rd", rd_ram, 0);
    chk("rst_wr", wrt_ram, 0);
    chk("rst_addr_ram", addr_ram, 0);
    chk("rst_dout", data_out, 0);
    reset = 0;
    exp_ram(0, 24'h000000, 0);
    exp_ack(1, 24'h000003, 8'h00);
    req(1, 24'h000003, 0, 0);
    exp_ack(0, 24'h000003, 8'h56);
    req(0, 24'h000003, 8'h56, 1);
    exp_ack(1, 24'h000003, 8'h56);
    req(1, 24'h000003, 0, 1);
    exp_ram(1, 24'h000000, 32'h56000000);
    exp_ram(0, 24'h010000, 0);
    exp_ack(1, 24'h010000, 8'h00);
    req(1, 24'h010000, 0, 0);
    exp_ram(0, 24'h000004, 0);
    exp_ack(0, 24'h000006, 8'h33);
    req(0, 24'h000006, 8'h33, 0);
    exp_ram(1, 24'h000004, 32'h00330000);
    exp_ram(0, 24'h020004, 0);
    exp_ack(0, 24'h020007, 8'h55);
    req(0, 24'h020007, 8'h55, 0);
    exp_ack(1, 24'h020007, 8'h55);
    req(1, 24'h020007, 0, 1);
    exp_ram(1, 24'h020004, 32'h55000000);
    exp_ram(0, 24'h000004, 0);
    exp_ack(1, 24'h000004, 8'h00);
    req(1, 24'h000004, 0, 0);
    exp_ack(0, 24'h000005, 8'h77);
    req(0, 24'h000005, 8'h77, 1);
    exp_ram(0, 24'h000000, 0);
    @(negedge clk);
    read = 1;
    addr = 24'h000000;
    @(negedge clk);
    read = 0;
    k = 0;
    while (!rd_ram && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("abort_fetch_up", rd_ram, 1);
    @(posedge clk);
    #2 reset = 1;
    #1;
    chk("abort_rd", rd_ram, 0);
    chk("abort_fetch", fetch, 0);
    chk("abort_busy", busy, 0);
    chk("abort_addr_ram", addr_ram, 0);
    @(negedge clk);
    reset = 0;
    exp_ram(0, 24'h000004, 0);
    exp_ack(1, 24'h000005, 8'h00);
    req(1, 24'h000005, 0, 0);
    exp_ram(0, 24'h000000, 0);
    exp_ack(1, 24'h000003, 8'h56);
    req(1, 24'h000003, 0, 0);
    exp_ram(0, 24'h040000, 0);
    exp_ack(1, 24'h040000, 8'h00);
    a0 = acks;
    @(negedge clk);
    read = 1;
    addr = 24'h040000;
    @(negedge clk);
    addr = 24'h000007;
    @(negedge clk);
    read = 0;
    @(negedge clk);
    read = 1;
    @(negedge clk);
    read = 0;
    k = 0;
    while (!ack && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("ack_busy_req", ack, 1);
    repeat (8) @(negedge clk);
    chk("one_ack", acks - a0, 1);
    chk("ackq_left", ackq.size(), 0);
    chk("ramq_left", ramq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
